rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer for the shared 4:1 multiplexer datapath. Four requesters
//   compete for the single mux output. The block grants one requester at a time, drives the
//   mux select and registers the selected data with a valid flag. Tenure is capped at
//   MAX_HOLD cycles so no requester can starve the others.
// PARAMETERS
//   WIDTH     1   data width per requester lane
//   MAX_HOLD  4   max consecutive granted cycles per tenure; legal range >=1
// PORTS
//   clk       in   1        single clock; all state updates on posedge clk
//   rst_n     in   1        synchronous, active-low reset; sampled on posedge clk
//   req       in   4        request per requester; level, held while data is wanted
//   in_bus    in   4*WIDTH  lane i = in_bus[i*WIDTH +: WIDTH]
//   gnt       out  4        one-hot grant, registered; all-zero when idle
//   sel       out  2        mux select = index of granted lane, registered
//   busy      out  1        1 while in GRANT state
//   out_data  out  WIDTH    registered mux output
//   out_valid out  1        out_data holds valid granted-lane data this cycle
// BEHAVIOUR
//   Reset (rst_n=0 at an edge, dominates all else): state=IDLE, gnt=0, sel=0, busy=0,
//     out_data=0, out_valid=0, ptr=0, hold_cnt=0. Mid-tenure reset drops the grant at that edge.
//   Priority search: first i in order ptr, ptr+1, ... (mod 4, 3 wraps to 0) with req[i]=1.
//   IDLE: if req!=0, next edge -> GRANT, gnt=onehot(winner), sel=winner, hold_cnt=0.
//     Latency req->gnt = 1 cycle. If req=0, stay IDLE; sel holds last value.
//   GRANT, owner o=sel, each edge:
//     release if req[o]=0 OR hold_cnt==MAX_HOLD-1; else hold_cnt<=hold_cnt+1.
//     on release: ptr<=(o+1) mod 4; re-search with the new ptr on the current req.
//       winner found -> gnt/sel switch at this edge (no idle gap), hold_cnt=0.
//       none -> IDLE, gnt=0, busy=0.
//     Released owner has lowest priority; if it is the sole requester it is re-granted
//       immediately with a fresh tenure (gnt stays constant).
//     MAX_HOLD=1: re-arbitration every cycle.
//   Data stage, 1 cycle after grant:
//     out_valid <= (state==GRANT) & req[sel];
//     out_data  <= lane[sel] when that term is 1, else holds.
//   Requests arriving in the release cycle are counted in that cycle's search.
//   gnt is always one-hot or zero; gnt!=0 iff busy=1.
// TESTING
//   1 Reset: rst_n=0 for 2 edges with req=4'b1111 -> gnt=0, sel=0, out_valid=0;
//     rst_n=1 -> gnt=4'b0001 at the next edge.
//   2 Fairness: req=4'b1111 held, MAX_HOLD=4 -> gnt 0001,0010,0100,1000,0001,
//     4 cycles each, no gap.
//   3 Sole requester: req=4'b0100 for 10 cycles -> gnt=4'b0100 and sel=2 throughout,
//     hold_cnt restarts every 4 cycles.
//   4 Handoff/wrap: grant lane 3, then drop req[3] while raising req[0] in the same cycle
//     -> gnt=0001 at the next edge; ptr wraps 3->0 -> lane 0 wins over lane 1.
//   5 Datapath: WIDTH=4, in_bus={4'hD,4'hC,4'hB,4'hA}, req=4'b0100 -> out_data=4'hC,
//     out_valid=1 one cycle after gnt; drop req -> out_valid=0 next edge, out_data holds 4'hC.
//   6 Reset mid-tenure: rst_n=0 while gnt=4'b0010 with req=4'b1111 -> all outputs 0;
//     after release gnt=4'b0001 (ptr reset to 0).

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux. Grants one requester at a time, caps tenure at
// MAX_HOLD cycles, and registers the selected lane with a valid flag one cycle behind the grant.
module rr_mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] in_bus,
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic               busy,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_n;
  logic [1:0]              ptr, ptr_n, sel_n, rel_ptr, srch_ptr;
  logic [HW-1:0]           hold_cnt, hold_n;
  logic [3:0]              gnt_n;
  logic                    rel;
  logic [2:0]              win;
  logic [3:0][WIDTH-1:0]   lane;

  assign lane = in_bus;
  assign busy = (state == GRANT);

  // {found, index} of the first requester at or after p, wrapping 3 -> 0
  function automatic logic [2:0] pick(input logic [1:0] p, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    hold_n   = hold_cnt;
    gnt_n    = gnt;
    sel_n    = sel;
    rel_ptr  = sel + 2'd1;
    rel      = !req[sel] || (hold_cnt == HW'(MAX_HOLD - 1));
    // In GRANT the search only matters on release, where it starts past the old owner
    srch_ptr = (state == GRANT) ? rel_ptr : ptr;
    win      = pick(srch_ptr, req);
    case (state)
      IDLE: begin
        if (win[2]) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << win[1:0];
          sel_n   = win[1:0];
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_n = rel_ptr;
          if (win[2]) begin
            gnt_n  = 4'b0001 << win[1:0];
            sel_n  = win[1:0];
            hold_n = '0;
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
          end
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      sel       <= sel_n;
      out_valid <= (state == GRANT) && req[sel];
      if ((state == GRANT) && req[sel]) out_data <= lane[sel];
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed scenarios plus randomized traffic, every cycle compared against a tenure-counting
// reference model of the round-robin rules.
module tb_rr_mux_arbiter;
  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] in_bus;
  logic [3:0]         gnt;
  logic [1:0]         sel;
  logic               busy;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;

  int total = 0;
  int bad   = 0;

  rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_bus(in_bus), .gnt(gnt), .sel(sel),
    .busy(busy), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // reference model: owner index (-1 idle), tenure length in cycles, rotating pointer
  int               m_owner  = -1;
  int               m_tenure = 0;
  int               m_ptr    = 0;
  int               m_sel    = 0;
  logic [WIDTH-1:0] m_od     = '0;
  logic             m_ov     = 1'b0;

  function automatic int search(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (!rst_n) begin
      m_owner = -1; m_tenure = 0; m_ptr = 0; m_sel = 0; m_od = '0; m_ov = 1'b0;
    end else begin
      m_ov = (m_owner >= 0) && req[m_sel];
      if (m_ov) m_od = in_bus[m_sel*WIDTH +: WIDTH];
      if (m_owner < 0) begin
        w = search(m_ptr, req);
        if (w >= 0) begin m_owner = w; m_sel = w; m_tenure = 1; end
      end else if (!req[m_owner] || m_tenure == MAX_HOLD) begin
        m_ptr = (m_owner + 1) % 4;
        w = search(m_ptr, req);
        if (w >= 0) begin m_owner = w; m_sel = w; m_tenure = 1; end
        else m_owner = -1;
      end else begin
        m_tenure++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one edge, then compare every output against the model on the falling edge
  task automatic cyc();
    logic [3:0] eg;
    @(posedge clk);
    @(negedge clk);
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("onehot", 32'($onehot0(gnt) && ((gnt != 0) == busy)), 32'd1);
  endtask

  task automatic wait_gnt(input logic [3:0] g, input string tag);
    int n = 0;
    while (gnt !== g && n < 20) begin cyc(); n++; end
    chk(tag, 32'(gnt), 32'(g));
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = 4'b1111;
    in_bus = 16'hDCBA;

    // reset held two edges with all requesting
    cyc(); cyc();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_ov", 32'(out_valid), 32'h0);

    // fairness: four cycles per lane, rotating, no gaps
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("fair", 32'(gnt), 32'(4'b0001 << ((k / 4) % 4)));
    end

    // sole requester keeps the grant across tenure boundaries
    req = 4'b0100;
    wait_gnt(4'b0100, "sole_acq");
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("sole_gnt", 32'(gnt), 32'h4);
      chk("sole_sel", 32'(sel), 32'h2);
    end

    // handoff with pointer wrap 3 -> 0
    req = 4'b1000;
    wait_gnt(4'b1000, "wrap_acq");
    req = 4'b0011;
    cyc();
    chk("wrap_gnt", 32'(gnt), 32'h1);

    // datapath: lane 2 carries C, valid one cycle after grant, data holds after drop
    req = 4'b0100;
    wait_gnt(4'b0100, "dp_acq");
    cyc();
    chk("dp_ov", 32'(out_valid), 32'h1);
    chk("dp_od", 32'(out_data), 32'hC);
    req = 4'b0000;
    cyc();
    chk("dp_ov_drop", 32'(out_valid), 32'h0);
    chk("dp_od_hold", 32'(out_data), 32'hC);
    chk("dp_idle", 32'(gnt), 32'h0);

    // reset mid-tenure
    req = 4'b1111;
    wait_gnt(4'b0010, "mid_acq");
    rst_n = 1'b0;
    cyc();
    chk("mid_gnt", 32'(gnt), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_ov", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    cyc();
    chk("mid_regrant", 32'(gnt), 32'h1);

    // randomized traffic with sparse resets
    for (int k = 0; k < 400; k++) begin
      req    = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      if ($urandom_range(0, 9) == 0) req = 4'b0000;
      in_bus = 16'($urandom);
      rst_n  = ($urandom_range(0, 49) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
